reg_wport_arbiter: RTL and testbench

Shares the single write port of the 8 x 8 register file between two writeback requesters: A (ALU result) and B (load data). It uses round-robin arbitration with a valid/grant handshake. It drives the register file's WRITE, INADDRESS and IN through a one-cycle registered stage. It also keeps a pending-write scoreboard so the decode stage can stall on registers whose writeback has not yet been issued.

---
 rtl/reg_wport_if.sv | 34 +++
 rtl/reg_wport_arbiter.sv | 99 +++++++++
 tb/tb_reg_wport_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_wport_if.sv
// Writeback bus between the two requesters, the decode-stage reservation
// and the register file write port.
interface reg_wport_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
);
  logic              EN;
  logic              REQ_A;
  logic [ADDR_W-1:0] ADDR_A;
  logic [DATA_W-1:0] DATA_A;
  logic              GNT_A;
  logic              REQ_B;
  logic [ADDR_W-1:0] ADDR_B;
  logic [DATA_W-1:0] DATA_B;
  logic              GNT_B;
  logic              RSV_EN;
  logic [ADDR_W-1:0] RSV_ADDR;
  logic              WRITE;
  logic [ADDR_W-1:0] INADDRESS;
  logic [DATA_W-1:0] IN;
  logic [NREG-1:0]   PENDING;
  logic              LAST_B;

  modport master (
    output EN, REQ_A, ADDR_A, DATA_A, REQ_B, ADDR_B, DATA_B, RSV_EN, RSV_ADDR,
    input  GNT_A, GNT_B, WRITE, INADDRESS, IN, PENDING, LAST_B
  );

  modport slave (
    input  EN, REQ_A, ADDR_A, DATA_A, REQ_B, ADDR_B, DATA_B, RSV_EN, RSV_ADDR,
    output GNT_A, GNT_B, WRITE, INADDRESS, IN, PENDING, LAST_B
  );
endinterface

// File: rtl/reg_wport_arbiter.sv
// Round-robin arbiter for the register file write port, with a registered
// write stage and a pending-write scoreboard for decode stalls.
module reg_wport_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
) (
  input logic       CLK,
  input logic       RESET,
  reg_wport_if.slave bus
);

  logic              gnt_a_s;
  logic              gnt_b_s;
  logic              write_q,   write_d;
  logic [ADDR_W-1:0] inaddr_q,  inaddr_d;
  logic [DATA_W-1:0] in_q,      in_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic              last_b_q,  last_b_d;

  function automatic logic [NREG-1:0] addr_onehot(input logic [ADDR_W-1:0] a);
    logic [NREG-1:0] oh;
    oh    = {NREG{1'b0}};
    oh[a] = 1'b1;
    return oh;
  endfunction

  // Grant selection; on a tie the requester not served last wins.
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    if (RESET || !bus.EN) begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end else if (bus.REQ_A && bus.REQ_B) begin
      gnt_a_s = last_b_q;
      gnt_b_s = ~last_b_q;
    end else begin
      gnt_a_s = bus.REQ_A;
      gnt_b_s = bus.REQ_B;
    end
  end

  // Next write stage, pointer and scoreboard state.
  always_comb begin
    write_d   = 1'b0;
    inaddr_d  = inaddr_q;
    in_d      = in_q;
    last_b_d  = last_b_q;
    pending_d = pending_q;
    if (gnt_a_s) begin
      write_d   = 1'b1;
      inaddr_d  = bus.ADDR_A;
      in_d      = bus.DATA_A;
      last_b_d  = 1'b0;
      pending_d = pending_q & ~addr_onehot(bus.ADDR_A);
    end else if (gnt_b_s) begin
      write_d   = 1'b1;
      inaddr_d  = bus.ADDR_B;
      in_d      = bus.DATA_B;
      last_b_d  = 1'b1;
      pending_d = pending_q & ~addr_onehot(bus.ADDR_B);
    end else begin
      write_d   = 1'b0;
    end
    // A fresh reservation supersedes a write retiring to the same register.
    if (bus.RSV_EN) begin
      pending_d = pending_d | addr_onehot(bus.RSV_ADDR);
    end else begin
      pending_d = pending_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      write_q   <= 1'b0;
      inaddr_q  <= {ADDR_W{1'b0}};
      in_q      <= {DATA_W{1'b0}};
      pending_q <= {NREG{1'b0}};
      last_b_q  <= 1'b1;
    end else begin
      write_q   <= write_d;
      inaddr_q  <= inaddr_d;
      in_q      <= in_d;
      pending_q <= pending_d;
      last_b_q  <= last_b_d;
    end
  end

  assign bus.GNT_A     = gnt_a_s;
  assign bus.GNT_B     = gnt_b_s;
  assign bus.WRITE     = write_q;
  assign bus.INADDRESS = inaddr_q;
  assign bus.IN        = in_q;
  assign bus.PENDING   = pending_q;
  assign bus.LAST_B    = last_b_q;

endmodule

// File: tb/tb_reg_wport_arbiter.sv
// Scoreboard bench for reg_wport_arbiter: directed scenarios followed by
// randomized traffic checked against a behavioural model.
module tb_reg_wport_arbiter;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  logic CLK;
  logic RESET;

  reg_wport_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) bus ();

  reg_wport_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: what the register file port should look like right now.
  int  m_last;          // 0 = A served most recently, 1 = B
  bit  m_write;
  int  m_addr;
  int  m_data;
  bit  m_pend [NREG];
  int  exp_q [$];       // expected writes, encoded addr*256 + data
  bit  started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] pend_word();
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < NREG; i++) if (m_pend[i]) w = w + (32'd1 << i);
    return w;
  endfunction

  task automatic model_reset();
    m_last  = 1;
    m_write = 1'b0;
    m_addr  = 0;
    m_data  = 0;
    for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
  endtask

  // One clock cycle: check state and grants mid-cycle, then advance the model.
  // winner: 0 none, 1 A, 2 B.
  task automatic cycle(output int winner);
    int addr;
    @(negedge CLK);
    chk("write",     {31'd0, bus.WRITE},            {31'd0, m_write});
    chk("inaddress", {29'd0, bus.INADDRESS},         m_addr);
    chk("in",        {24'd0, bus.IN},                m_data);
    chk("pending",   {24'd0, bus.PENDING},           pend_word());
    chk("last_b",    {31'd0, bus.LAST_B},            m_last);
    winner = 0;
    if (!RESET && bus.EN) begin
      if (bus.REQ_A && bus.REQ_B) winner = (m_last == 1) ? 1 : 2;
      else if (bus.REQ_A)         winner = 1;
      else if (bus.REQ_B)         winner = 2;
    end
    chk("gnt_a", {31'd0, bus.GNT_A}, (winner == 1) ? 32'd1 : 32'd0);
    chk("gnt_b", {31'd0, bus.GNT_B}, (winner == 2) ? 32'd1 : 32'd0);
    if (RESET) begin
      model_reset();
    end else begin
      m_write = (winner != 0);
      if (winner != 0) begin
        m_addr = (winner == 1) ? int'(bus.ADDR_A) : int'(bus.ADDR_B);
        m_data = (winner == 1) ? int'(bus.DATA_A) : int'(bus.DATA_B);
        m_last = (winner == 2) ? 1 : 0;
        m_pend[m_addr] = 1'b0;
        exp_q.push_back(m_addr * 256 + m_data);
      end
      if (bus.RSV_EN) m_pend[bus.RSV_ADDR] = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every presented write must match the oldest expected one.
  always @(negedge CLK) begin
    if (started && bus.WRITE === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {29'd0, bus.INADDRESS}, 32'hFFFF_FFFF);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("sb_addr", {29'd0, bus.INADDRESS}, e / 256);
        chk("sb_data", {24'd0, bus.IN},        e % 256);
      end
    end
  end

  initial begin
    int w;
    RESET = 1'b1;
    bus.EN = 1'b1;
    bus.REQ_A = 1'b0; bus.ADDR_A = '0; bus.DATA_A = '0;
    bus.REQ_B = 1'b0; bus.ADDR_B = '0; bus.DATA_B = '0;
    bus.RSV_EN = 1'b0; bus.RSV_ADDR = '0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    RESET = 1'b0;
    started = 1'b1;

    // Reset then idle
    cycle(w);
    chk("idle_no_grant", w, 0);

    // Single requester A
    bus.REQ_A = 1'b1; bus.ADDR_A = 3'd3; bus.DATA_A = 8'h5A;
    cycle(w);
    chk("single_grant", w, 1);
    bus.REQ_A = 1'b0;
    cycle(w);
    chk("single_inaddr", {29'd0, bus.INADDRESS}, 32'd3);
    cycle(w);

    // Tie after reset: A, B, A, B
    RESET = 1'b1; cycle(w); RESET = 1'b0;
    bus.REQ_A = 1'b1; bus.ADDR_A = 3'd1; bus.DATA_A = 8'h11;
    bus.REQ_B = 1'b1; bus.ADDR_B = 3'd2; bus.DATA_B = 8'h22;
    for (int i = 0; i < 4; i++) begin
      cycle(w);
      chk("tie_order", w, (i % 2 == 0) ? 1 : 2);
    end

    // Stall with both requesting, then resume from pointer (B was last)
    bus.EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(w);
      chk("stall_no_grant", w, 0);
    end
    bus.EN = 1'b1;
    cycle(w);
    chk("stall_resume", w, 1);
    bus.REQ_A = 1'b0; bus.REQ_B = 1'b0;
    cycle(w);

    // Scoreboard: reserve 5, reserve+retire 5, retire 5 via B
    bus.RSV_EN = 1'b1; bus.RSV_ADDR = 3'd5;
    cycle(w);
    bus.REQ_A = 1'b1; bus.ADDR_A = 3'd5; bus.DATA_A = 8'hA5;
    cycle(w);
    chk("rsv_pending", {24'd0, bus.PENDING}, 32'h20);
    bus.RSV_EN = 1'b0; bus.REQ_A = 1'b0;
    cycle(w);
    chk("set_wins", {24'd0, bus.PENDING}, 32'h20);
    bus.REQ_B = 1'b1; bus.ADDR_B = 3'd5; bus.DATA_B = 8'hB5;
    cycle(w);
    bus.REQ_B = 1'b0;
    cycle(w);
    chk("retire_clear", {24'd0, bus.PENDING}, 32'h00);

    // Reset in the cycle B would be granted
    bus.RSV_EN = 1'b1; bus.RSV_ADDR = 3'd6;
    cycle(w);
    bus.RSV_EN = 1'b0;
    bus.REQ_B = 1'b1; bus.ADDR_B = 3'd4; bus.DATA_B = 8'hC3;
    RESET = 1'b1;
    cycle(w);
    chk("reset_blocks_grant", w, 0);
    RESET = 1'b0;
    cycle(w);
    chk("regrant_after_reset", w, 2);
    bus.REQ_B = 1'b0;
    cycle(w);

    // Randomized traffic; requesters hold until granted
    for (int n = 0; n < 600; n++) begin
      RESET  = ($urandom_range(0, 49) == 0);
      bus.EN = ($urandom_range(0, 7) != 0);
      if (!bus.REQ_A && $urandom_range(0, 1) == 1) begin
        bus.REQ_A = 1'b1;
        bus.ADDR_A = 3'($urandom_range(0, NREG - 1));
        bus.DATA_A = 8'($urandom_range(0, 255));
      end
      if (!bus.REQ_B && $urandom_range(0, 1) == 1) begin
        bus.REQ_B = 1'b1;
        bus.ADDR_B = 3'($urandom_range(0, NREG - 1));
        bus.DATA_B = 8'($urandom_range(0, 255));
      end
      bus.RSV_EN   = ($urandom_range(0, 3) == 0);
      bus.RSV_ADDR = 3'($urandom_range(0, NREG - 1));
      cycle(w);
      if (w == 1) bus.REQ_A = 1'b0;
      if (w == 2) bus.REQ_B = 1'b0;
    end

    // Drain
    RESET = 1'b0; bus.REQ_A = 1'b0; bus.REQ_B = 1'b0; bus.RSV_EN = 1'b0;
    repeat (3) cycle(w);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
